// File: rtl/param_cache_system.sv
// param_cache_system: 2-way set-associative cache with LRU replacement and a
// miss FSM that bursts a whole line in from main memory.
module param_cache_system #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 16,
   parameter int WORDS_PER_LINE = 8,
   parameter int NUM_SETS       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              proceed,
   input  logic              on_chip_wr,
   input  logic [ADDR_W-1:0] on_chip_memory_address,
   input  logic [DATA_W-1:0] on_chip_memory_data,
   input  logic [DATA_W-1:0] off_chip_memory_data,
   input  logic              memory_data_valid,
   output logic [ADDR_W-1:0] off_chip_memory_address,
   output logic              off_chip_rd,
   output logic              fsm_busy,
   output logic [DATA_W-1:0] data_out,
   output logic              hit
);
   localparam int OW = $clog2(WORDS_PER_LINE);
   localparam int IW = $clog2(NUM_SETS);
   localparam int LW = ADDR_W - OW - 1;
   localparam int TW = LW - IW;

   typedef enum logic [1:0] {IDLE, WAIT, FILL} state_t;
   state_t state, state_nx;

   logic [LW-1:0]            miss_line;
   logic [OW:0]              issue_cnt;
   logic [OW-1:0]            recv_cnt;
   logic                     victim;
   logic [1:0][NUM_SETS-1:0] valid;
   logic [NUM_SETS-1:0]      lru;
   logic [TW-1:0]            tags  [2][NUM_SETS];
   logic [DATA_W-1:0]        lines [2][NUM_SETS][WORDS_PER_LINE];

   logic [OW-1:0] off;
   logic [IW-1:0] idx, fill_idx, vic_idx;
   logic [TW-1:0] tag, fill_tag;
   logic          match0, match1, hit_way, miss, go_fill, last, vic_sel, unused;

   assign off      = on_chip_memory_address[OW:1];
   assign idx      = on_chip_memory_address[OW+IW:OW+1];
   assign tag      = on_chip_memory_address[ADDR_W-1:OW+IW+1];
   assign unused   = on_chip_memory_address[0];
   assign fill_idx = miss_line[IW-1:0];
   assign fill_tag = miss_line[LW-1:IW];

   always_comb begin
      match0   = valid[0][idx] && tags[0][idx] == tag;
      match1   = valid[1][idx] && tags[1][idx] == tag;
      hit      = enable && !fsm_busy && (match0 || match1);
      hit_way  = !match0;
      data_out = hit ? lines[hit_way][idx][off] : '0;
      miss     = state == IDLE && enable && !hit;
      go_fill  = proceed && (state == WAIT || miss);
      last     = state == FILL && memory_data_valid && &recv_cnt;
      vic_idx  = state == IDLE ? idx : fill_idx;
      vic_sel  = !valid[0][vic_idx] ? 1'b0 : !valid[1][vic_idx] ? 1'b1 : lru[vic_idx];
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;

   always_comb
      state_nx = state == IDLE ? (miss ? (proceed ? FILL : WAIT) : IDLE)
               : state == WAIT ? (proceed ? FILL : WAIT)
               : (last ? IDLE : FILL);

   always_comb begin
      fsm_busy                = state != IDLE;
      off_chip_rd             = state == FILL && !issue_cnt[OW];
      off_chip_memory_address = state == FILL ? {miss_line, issue_cnt[OW-1:0], 1'b0} : '0;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         valid     <= '0;
         lru       <= '0;
         issue_cnt <= '0;
         recv_cnt  <= '0;
         miss_line <= '0;
         victim    <= 1'b0;
      end else begin
         if (miss) miss_line <= on_chip_memory_address[ADDR_W-1:OW+1];
         if (go_fill) victim <= vic_sel;
         if (off_chip_rd) issue_cnt <= issue_cnt + 1'b1;
         // recv_cnt wraps back to zero on the final word by construction
         if (state == FILL && memory_data_valid) recv_cnt <= recv_cnt + 1'b1;
         if (last) begin
            issue_cnt                <= '0;
            valid[victim][fill_idx]  <= 1'b1;
            lru[fill_idx]            <= ~victim;
         end
         if (hit) lru[idx] <= ~hit_way;
      end

   // Tag and data arrays carry no reset; only the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (hit && on_chip_wr) lines[hit_way][idx][off] <= on_chip_memory_data;
      if (state == FILL && memory_data_valid) lines[victim][fill_idx][recv_cnt] <= off_chip_memory_data;
      if (last) tags[victim][fill_idx] <= fill_tag;
   end
endmodule
